// File: rtl/compute_bus_master_pkg.sv
// Shared types and constants for initiators that talk to the compute accelerator slave.
package compute_pkg;
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RD_SUM,
        WAIT_SUM,
        RD_EVEN,
        WAIT_EVEN,
        DONE
    } state_t;

    localparam logic [3:0]  ADDR_SUM   = 4'd8;
    localparam logic [3:0]  ADDR_EVEN  = 4'd9;
    localparam int unsigned SLOT_COUNT = 8;
endpackage

// File: rtl/compute_bus_master_if.sv
// Host command/status, operand stream and slave bus signals of the compute initiator.
interface compute_bus_master_if;
    logic        iStart;
    logic        iOpValid;
    logic [31:0] iOpData;
    logic        oOpReady;
    logic        oChipSelect_n;
    logic        oWrite_n;
    logic        oRead_n;
    logic [3:0]  oAddress;
    logic [31:0] oData;
    logic [31:0] iData;
    logic [31:0] oSum;
    logic        oEven;
    logic        oError;
    logic        oBusy;
    logic        oDone;

    modport master (
        input  iStart, iOpValid, iOpData, iData,
        output oOpReady, oChipSelect_n, oWrite_n, oRead_n, oAddress, oData,
               oSum, oEven, oError, oBusy, oDone
    );

    modport slave (
        output iStart, iOpValid, iOpData, iData,
        input  oOpReady, oChipSelect_n, oWrite_n, oRead_n, oAddress, oData,
               oSum, oEven, oError, oBusy, oDone
    );
endinterface

// File: rtl/compute_bus_master_bus_if.sv
// Registered strobe/address/data driver for the compute slave bus, plus the read-latency
// counter that flags the cycle in which slave read data is valid.
module compute_bus_if #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_data,
    output logic        cs_n,
    output logic        write_n,
    output logic        read_n,
    output logic [3:0]  address,
    output logic [31:0] wdata,
    output logic        rd_valid
);
    logic [3:0] lat_cnt;
    logic       rd_pending;

    // A request in cycle t becomes the bus cycle t+1; a write request wins over a read.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_n    <= 1'b1;
            write_n <= 1'b1;
            read_n  <= 1'b1;
            address <= '0;
            wdata   <= '0;
        end else begin
            cs_n    <= ~(wr_req | rd_req);
            write_n <= ~wr_req;
            read_n  <= ~(rd_req & ~wr_req);
            if (wr_req | rd_req) address <= req_addr;
            if (wr_req)          wdata   <= req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pending <= 1'b0;
            lat_cnt    <= '0;
        end else if (rd_req) begin
            rd_pending <= 1'b1;
            lat_cnt    <= '0;
        end else if (rd_valid) begin
            rd_pending <= 1'b0;
        end else if (rd_pending) begin
            lat_cnt    <= lat_cnt + 4'd1;
        end
    end

    // Counter is zero during the strobe cycle itself.
    assign rd_valid = rd_pending && (lat_cnt == 4'(READ_LATENCY));
endmodule

// File: rtl/compute_bus_master.sv
// Streams operands into the compute slave's slots, reads back the sum and even flag,
// and cross-checks them against a locally accumulated sum.
module compute_bus_master #(
    parameter int unsigned NUM_OPERANDS = compute_pkg::SLOT_COUNT,
    parameter logic [3:0]  ADDR_SUM     = compute_pkg::ADDR_SUM,
    parameter logic [3:0]  ADDR_EVEN    = compute_pkg::ADDR_EVEN,
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          CHECK_EN     = 1'b1
) (
    input logic                  iClk,
    input logic                  iReset,
    compute_bus_master_if.master bus
);
    import compute_pkg::*;

    state_t      state, state_next;
    logic [3:0]  idx;
    logic [31:0] acc;
    logic [31:0] sum_q;
    logic [31:0] sum_out;
    logic        even_out;
    logic        error_out;
    logic        op_fire;
    logic        rd_req;
    logic        rd_valid;
    logic [3:0]  req_addr;

    assign op_fire = (state == LOAD) && bus.iOpValid;

    compute_bus_if #(.READ_LATENCY(READ_LATENCY)) u_bus (
        .clk      (iClk),
        .rst      (iReset),
        .wr_req   (op_fire),
        .rd_req   (rd_req),
        .req_addr (req_addr),
        .req_data (bus.iOpData),
        .cs_n     (bus.oChipSelect_n),
        .write_n  (bus.oWrite_n),
        .read_n   (bus.oRead_n),
        .address  (bus.oAddress),
        .wdata    (bus.oData),
        .rd_valid (rd_valid)
    );

    always_ff @(posedge iClk) begin
        if (iReset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        rd_req     = 1'b0;
        req_addr   = idx;
        case (state)
            IDLE:      if (bus.iStart) state_next = LOAD;
            LOAD:      if (op_fire && idx == 4'(NUM_OPERANDS - 1)) state_next = RD_SUM;
            RD_SUM: begin
                rd_req     = 1'b1;
                req_addr   = ADDR_SUM;
                state_next = WAIT_SUM;
            end
            WAIT_SUM:  if (rd_valid) state_next = RD_EVEN;
            RD_EVEN: begin
                rd_req     = 1'b1;
                req_addr   = ADDR_EVEN;
                state_next = WAIT_EVEN;
            end
            WAIT_EVEN: if (rd_valid) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // The sum is held privately until the even read lands so an abort never publishes half a result.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            idx       <= '0;
            acc       <= '0;
            sum_q     <= '0;
            sum_out   <= '0;
            even_out  <= 1'b0;
            error_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.iStart) begin
                    idx       <= '0;
                    acc       <= '0;
                    error_out <= 1'b0;
                end
                LOAD: if (op_fire) begin
                    idx <= idx + 4'd1;
                    acc <= acc + bus.iOpData;
                end
                WAIT_SUM: if (rd_valid) sum_q <= bus.iData;
                WAIT_EVEN: if (rd_valid) begin
                    sum_out   <= sum_q;
                    even_out  <= bus.iData[0];
                    error_out <= CHECK_EN && ((sum_q != acc) || (bus.iData[0] != ~acc[0]));
                end
                default: ;
            endcase
        end
    end

    assign bus.oOpReady = (state == LOAD);
    assign bus.oBusy    = (state != IDLE);
    assign bus.oDone    = (state == DONE);
    assign bus.oSum     = sum_out;
    assign bus.oEven    = even_out;
    assign bus.oError   = error_out;
endmodule

// File: tb/tb_compute_bus_master.sv
// Self-checking bench for compute_bus_master: slave model on the bus, table vectors,
// randomized vectors against a plain-arithmetic reference, and reset/abort sequences.
module tb_compute_bus_master;
    logic iClk   = 1'b0;
    logic iReset = 1'b1;

    compute_bus_master_if bus();

    compute_bus_master dut (
        .iClk   (iClk),
        .iReset (iReset),
        .bus    (bus)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic [7:0][31:0] ops;
        logic [7:0]       gaps;
        logic             corrupt;
        logic             poke;
        logic [31:0]      expSum;
        logic             expEven;
        logic             expErr;
    } vec_t;

    int          vectors     = 0;
    int          miscompares = 0;
    int          protoErrs   = 0;
    int          doneCount   = 0;
    int          cycle       = 0;
    logic [31:0] slots [8];
    logic [31:0] lastTrueSum = '0;
    logic [31:0] readResp    = '0;
    bit          readPending = 1'b0;
    bit          corruptSum  = 1'b0;
    int          wrAddr [$];
    logic [31:0] wrData [$];
    int          wrCycle [$];
    int          rdAddr [$];
    vec_t        vecTable [5];

    always @(posedge iClk) cycle++;

    always @(negedge iClk) if (bus.oDone === 1'b1) doneCount++;

    // Slave model: one-cycle read latency, garbage on iData in every cycle that is not a response.
    always @(negedge iClk) begin
        int lows;
        lows = int'(bus.oWrite_n == 1'b0) + int'(bus.oRead_n == 1'b0);
        if (lows > 1 || bus.oChipSelect_n != (lows == 0)) protoErrs++;
        if (readPending) bus.iData = readResp;
        else             bus.iData = $urandom();
        readPending = 1'b0;
        if (!bus.oChipSelect_n && !bus.oWrite_n) begin
            if (bus.oAddress < 4'd8) slots[bus.oAddress[2:0]] = bus.oData;
            wrAddr.push_back(int'(bus.oAddress));
            wrData.push_back(bus.oData);
            wrCycle.push_back(cycle);
        end
        if (!bus.oChipSelect_n && !bus.oRead_n) begin
            readPending = 1'b1;
            rdAddr.push_back(int'(bus.oAddress));
            if (bus.oAddress == 4'd8) begin
                lastTrueSum = '0;
                for (int k = 0; k < 8; k++) lastTrueSum += slots[k];
                readResp = lastTrueSum + 32'(corruptSum);
            end else if (bus.oAddress == 4'd9) begin
                readResp = ($urandom() & ~32'h1) | {31'b0, ~lastTrueSum[0]};
            end else begin
                readResp = '0;
            end
        end
    end

    function automatic logic [31:0] modelSum(input logic [7:0][31:0] ops);
        longint unsigned s;
        s = 0;
        for (int i = 0; i < 8; i++) s += longint'(ops[i]);
        return 32'(s % 64'h1_0000_0000);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int waitCnt;
        int base;
        int bad;
        bit seen;
        base = doneCount;
        wrAddr.delete();
        wrData.delete();
        wrCycle.delete();
        rdAddr.delete();
        corruptSum = v.corrupt;
        @(negedge iClk);
        bus.iStart = 1'b1;
        @(negedge iClk);
        bus.iStart = v.poke;
        checkOutput("startReady", 32'(bus.oOpReady), 32'd1);
        checkOutput("errClear", 32'(bus.oError), 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (v.gaps[i]) begin
                bus.iOpValid = 1'b0;
                @(negedge iClk);
            end
            bus.iOpValid = 1'b1;
            bus.iOpData  = v.ops[i];
            waitCnt = 0;
            while (!bus.oOpReady && waitCnt < 20) begin
                @(negedge iClk);
                waitCnt++;
            end
            if (!bus.oOpReady) begin
                checkOutput("readyTimeout", 32'(bus.oOpReady), 32'd1);
                break;
            end
            @(negedge iClk);
        end
        bus.iOpValid = 1'b0;
        bus.iStart   = 1'b0;
        seen    = 1'b0;
        waitCnt = 0;
        while (!seen && waitCnt < 60) begin
            if (bus.oDone) seen = 1'b1;
            else begin
                @(negedge iClk);
                waitCnt++;
            end
        end
        checkOutput("doneSeen", 32'(seen), 32'd1);
        checkOutput("sum", bus.oSum, v.expSum);
        checkOutput("even", 32'(bus.oEven), 32'(v.expEven));
        checkOutput("error", 32'(bus.oError), 32'(v.expErr));
        if (v.poke) bus.iStart = 1'b1;
        @(negedge iClk);
        bus.iStart = 1'b0;
        checkOutput("donePulse", 32'(bus.oDone), 32'd0);
        repeat (3) @(negedge iClk);
        checkOutput("idleBusy", 32'(bus.oBusy), 32'd0);
        checkOutput("doneCount", 32'(doneCount - base), 32'd1);
        checkOutput("sumHold", bus.oSum, v.expSum);
        checkOutput("errHold", 32'(bus.oError), 32'(v.expErr));
        checkOutput("wrCount", 32'(wrAddr.size()), 32'd8);
        bad = 0;
        for (int i = 0; i < wrAddr.size() && i < 8; i++) begin
            if (wrAddr[i] != i || wrData[i] !== v.ops[i]) bad++;
            if (i > 0 && wrCycle[i] - wrCycle[i-1] != 1 + int'(v.gaps[i])) bad++;
        end
        checkOutput("wrOrder", 32'(bad), 32'd0);
        bad = (rdAddr.size() != 2) ? 1 : ((rdAddr[0] != 8 || rdAddr[1] != 9) ? 1 : 0);
        checkOutput("rdOrder", 32'(bad), 32'd0);
        checkOutput("protocol", 32'(protoErrs), 32'd0);
    endtask

    initial begin
        bus.iStart   = 1'b0;
        bus.iOpValid = 1'b0;
        bus.iOpData  = '0;
        for (int k = 0; k < 8; k++) slots[k] = '0;

        for (int t = 0; t < 5; t++) begin
            vecTable[t] = '0;
            for (int i = 0; i < 8; i++) vecTable[t].ops[i] = 32'(i + 1);
        end
        vecTable[0].expSum = 32'd36; vecTable[0].expEven = 1'b1;
        vecTable[1].ops[6:0] = {7{32'd1}}; vecTable[1].ops[7] = 32'd2;
        vecTable[1].gaps = 8'hFE; vecTable[1].expSum = 32'd9;
        vecTable[2].ops = '0; vecTable[2].ops[0] = 32'hFFFF_FFFF; vecTable[2].ops[1] = 32'd1;
        vecTable[2].expSum = 32'd0; vecTable[2].expEven = 1'b1;
        vecTable[3].corrupt = 1'b1; vecTable[3].expSum = 32'd37;
        vecTable[3].expEven = 1'b1; vecTable[3].expErr = 1'b1;
        vecTable[4].poke = 1'b1; vecTable[4].expSum = 32'd36; vecTable[4].expEven = 1'b1;

        repeat (3) @(negedge iClk);
        checkOutput("rstStrobes", {29'b0, bus.oChipSelect_n, bus.oWrite_n, bus.oRead_n}, 32'd7);
        checkOutput("rstAddr", 32'(bus.oAddress), 32'd0);
        checkOutput("rstData", bus.oData, 32'd0);
        checkOutput("rstSum", bus.oSum, 32'd0);
        checkOutput("rstFlags", {27'b0, bus.oEven, bus.oError, bus.oDone, bus.oBusy, bus.oOpReady}, 32'd0);
        iReset = 1'b0;

        // Abort after the fourth write reaches the bus.
        @(negedge iClk);
        bus.iStart = 1'b1;
        @(negedge iClk);
        bus.iStart = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.iOpValid = 1'b1;
            bus.iOpData  = 32'(100 + i);
            @(negedge iClk);
        end
        bus.iOpValid = 1'b0;
        checkOutput("abortWr", {30'b0, bus.oChipSelect_n, bus.oWrite_n}, 32'd0);
        checkOutput("abortAddr", 32'(bus.oAddress), 32'd3);
        iReset = 1'b1;
        @(negedge iClk);
        checkOutput("abortStrobes", {29'b0, bus.oChipSelect_n, bus.oWrite_n, bus.oRead_n}, 32'd7);
        checkOutput("abortBusy", 32'(bus.oBusy), 32'd0);
        checkOutput("abortSum", bus.oSum, 32'd0);
        checkOutput("abortReady", 32'(bus.oOpReady), 32'd0);
        iReset = 1'b0;
        @(negedge iClk);

        for (int t = 0; t < 5; t++) applyStimulus(vecTable[t]);

        for (int r = 0; r < 6; r++) begin
            vec_t        v;
            logic [31:0] s;
            v = '0;
            for (int i = 0; i < 8; i++) v.ops[i] = $urandom();
            v.gaps    = 8'($urandom_range(0, 255));
            v.corrupt = 1'($urandom_range(0, 1));
            v.poke    = 1'($urandom_range(0, 1));
            s         = modelSum(v.ops);
            v.expSum  = s + 32'(v.corrupt);
            v.expEven = (s % 2 == 0);
            v.expErr  = v.corrupt;
            applyStimulus(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/compute_bus_master.md
Name: compute_bus_master

Overview:
- Initiator for the compute accelerator's memory-mapped slave port: chip-select, write strobe, read strobe, 4-bit address, 32-bit data.
- Accepts eight 32-bit operands on a valid/ready stream and writes them to slots 0..7.
- Then reads the sum register (address 8) and the even-parity flag (address 9), and returns both with a done pulse.
- Sits between the host-side command logic and the compute slave in the SoC fabric.

Parameters:
- NUM_OPERANDS, 8, operand count and write address range 0..NUM_OPERANDS-1; must be ≤ 8.
- ADDR_SUM, 4'd8, slave address of the sum read.
- ADDR_EVEN, 4'd9, slave address of the even flag (1 = even sum, 0 = odd).
- READ_LATENCY, 1, cycles from read-strobe cycle to valid slave read data.
- CHECK_EN, 1, enables the local sum/flag cross-check.

Ports:
- iClk  in  1  clock.
- iReset  in  1  synchronous active-high reset.
- iStart  in  1  begin a transaction; sampled only in IDLE.
- iOpValid  in  1  operand valid.
- iOpData  in  32  operand value.
- oOpReady  out  1  operand accepted when iOpValid&&oOpReady.
- oChipSelect_n  out  1  bus chip select, active low.
- oWrite_n  out  1  bus write strobe, active low.
- oRead_n  out  1  bus read strobe, active low.
- oAddress  out  4  bus address.
- oData  out  32  bus write data.
- iData  in  32  bus read data from slave.
- oSum  out  32  captured sum.
- oEven  out  1  captured even flag.
- oError  out  1  cross-check mismatch.
- oBusy  out  1  high in any state other than IDLE.
- oDone  out  1  one-cycle completion pulse.

Behaviour:
- One clock: iClk. Reset is synchronous and active-high: iReset.
- Reset values:
  - oChipSelect_n=1, oWrite_n=1, oRead_n=1.
  - oAddress=0, oData=0.
  - oSum=0, oEven=0, oError=0, oDone=0, oBusy=0, oOpReady=0.
  - State IDLE, index=0, local accumulator=0.
- Reset mid-transaction aborts immediately. Bus strobes deassert in the next cycle; no partial read results are published.
- All bus outputs are registered. At most one strobe is low per cycle. Chip select is low exactly when a strobe is low.
- IDLE:
  - oOpReady=0.
  - iStart=1 → LOAD, with index=0 and accumulator=0.
- LOAD:
  - oOpReady=1.
  - On accept at cycle t, cycle t+1 drives a write with address=index and data=iOpData.
  - Accumulator += iOpData, modulo 2^32 with no saturation. index increments.
  - Gaps in iOpValid produce idle bus cycles with strobes high; no timeout.
  - On the NUM_OPERANDS-th accept, oOpReady drops in the next cycle → RD_SUM.
- RD_SUM: one cycle with read strobe low and address ADDR_SUM → WAIT_SUM.
- WAIT_SUM: strobes high. Capture iData into oSum at the end of cycle READ_LATENCY after the strobe cycle → RD_EVEN.
- The sum read always precedes the even read, because the slave updates its flag source only on a sum read.
- RD_EVEN / WAIT_EVEN: same pattern at ADDR_EVEN. Capture iData[0] into oEven → DONE.
- DONE:
  - oDone=1 for one cycle.
  - If CHECK_EN: oError=1 when oSum≠accumulator or oEven≠~accumulator[0].
  - oError is held until the next iStart accept.
  - → IDLE.
- iStart while busy is ignored. iStart in the DONE cycle is ignored. oSum and oEven hold until overwritten by the next transaction.
- Back-to-back: iStart may be accepted in the IDLE cycle immediately after DONE.

Decomposition:
- Shared package compute_pkg holds:
  - The state enum (IDLE, LOAD, RD_SUM, WAIT_SUM, RD_EVEN, WAIT_EVEN, DONE).
  - Slave address constants ADDR_SUM and ADDR_EVEN.
  - The slot count of 8.
- One sub-module, compute_bus_if, is natural. It holds the registered strobe, address and data driver plus the read-latency capture counter, shared with future initiators.

Test Plan:
- Operands 1..8, no gaps, slave model attached → 8 writes at addresses 0..7 on consecutive cycles, then reads at 8 and 9; oSum=36, oEven=1, oError=0, oDone pulses once.
- Operands 1,1,1,1,1,1,1,2 with one-cycle iOpValid gaps → idle bus cycles between writes; oSum=9, oEven=0.
- Operands 0xFFFFFFFF,1,0,0,0,0,0,0 → oSum=0 (wrap), oEven=1, oError=0.
- Slave model that corrupts the sum read to 37 for operands 1..8 → oSum=37, oError=1 held until the next iStart.
- iReset asserted after the 4th write → next cycle all strobes high, oBusy=0, oSum unchanged; a fresh iStart runs cleanly.
- iStart pulsed during LOAD and in the DONE cycle → ignored; exactly one oDone per accepted start.
